// File: rtl/ps2_pkg.sv
// Shared constants and frame-FSM state encoding for the PS/2 scan-code receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // PS/2 uses odd parity: data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_pin_filter.sv
// Synchroniser plus run-length glitch filter for one PS/2 pin; emits a one-cycle
// strobe on each accepted falling edge of the filtered level.
module ps2_pin_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic fall_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;
  logic                   level_q, level_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   fall_q, fall_d;

  assign sample = sync_q[SYNC_STAGES-1];
  assign fall_o = fall_q;

  // The level only flips once FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    fall_d  = 1'b0;
    if (sample != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sample;
        fall_d  = ~sample;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
    end
  end

endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: deserialises device-to-host frames, checks parity/stop,
// and folds E0/F0 prefixes into a single decoded key event.
module ps2_scan_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk_100Mhz,
  input  logic       rst_n,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic       err_parity,
  output logic       err_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] dsync_q;
  logic                   data_s;
  logic                   clk_fall;

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [7:0]    key_code_q, key_code_d;
  logic          key_ext_q, key_ext_d, key_break_q, key_break_d;
  logic          key_valid_q, key_valid_d;
  logic          err_par_q, err_par_d, err_tmo_q, err_tmo_d;

  ps2_pin_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_clk_filter (
    .clk_i  (clk_100Mhz),
    .rst_ni (rst_n),
    .pin_i  (PS2Clk),
    .fall_o (clk_fall)
  );

  assign data_s = dsync_q[SYNC_STAGES-1];

  // Strobes are single-cycle with no back-pressure: key_valid qualifies key_code/key_ext/
  // key_break in the cycle it is high, and at most one of key_valid/err_* is ever high.
  assign key_code    = key_code_q;
  assign key_ext     = key_ext_q;
  assign key_break   = key_break_q;
  assign key_valid   = key_valid_q;
  assign err_parity  = err_par_q;
  assign err_timeout = err_tmo_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    tmo_d       = tmo_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_break_d = key_break_q;
    key_valid_d = 1'b0;
    err_par_d   = 1'b0;
    err_tmo_d   = 1'b0;
    if (clk_fall) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!data_s) begin
            state_d   = ST_RECV;
            bit_cnt_d = 3'd0;
          end
        end
        ST_RECV: begin
          shift_d = {data_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end
        ST_PARITY: begin
          par_d   = data_s;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          state_d   = ST_IDLE;
          bit_cnt_d = 3'd0;
          if (data_s && odd_parity_ok(shift_q, par_q)) begin
            if (shift_q == PS2_PREFIX_EXT) begin
              ext_d = 1'b1;
            end else if (shift_q == PS2_PREFIX_BRK) begin
              brk_d = 1'b1;
            end else begin
              key_code_d  = shift_q;
              key_ext_d   = ext_q;
              key_break_d = brk_q;
              key_valid_d = 1'b1;
              ext_d       = 1'b0;
              brk_d       = 1'b0;
            end
          end else begin
            err_par_d = 1'b1;
            ext_d     = 1'b0;
            brk_d     = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      // A keyboard that stops clocking mid-frame must not wedge the receiver.
      if (tmo_q == TMO_LAST) begin
        err_tmo_d = 1'b1;
        state_d   = ST_IDLE;
        bit_cnt_d = 3'd0;
        ext_d     = 1'b0;
        brk_d     = 1'b0;
        tmo_d     = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      dsync_q     <= '1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      key_code_q  <= 8'h00;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      key_valid_q <= 1'b0;
      err_par_q   <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      dsync_q     <= {dsync_q[SYNC_STAGES-2:0], PS2Data};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_break_q <= key_break_d;
      key_valid_q <= key_valid_d;
      err_par_q   <= err_par_d;
      err_tmo_q   <= err_tmo_d;
    end
  end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Bench for ps2_scan_receiver: directed frame scenarios plus randomized frames, checked
// against a byte-level model of prefix folding and error handling.
module tb_ps2_scan_receiver;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int SYNC_STAGES    = 2;
  localparam int HALF           = 20;
  localparam int GAP            = 40;

  localparam logic [1:0] EV_KEY = 2'd1;
  localparam logic [1:0] EV_PAR = 2'd2;
  localparam logic [1:0] EV_TMO = 2'd3;

  logic       clk_100Mhz = 1'b0;
  logic       rst_n;
  logic       PS2Clk;
  logic       PS2Data;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic       err_parity;
  logic       err_timeout;

  ps2_scan_receiver #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) dut (
    .clk_100Mhz  (clk_100Mhz),
    .rst_n       (rst_n),
    .PS2Clk      (PS2Clk),
    .PS2Data     (PS2Data),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_break   (key_break),
    .key_valid   (key_valid),
    .err_parity  (err_parity),
    .err_timeout (err_timeout)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_100Mhz = ~clk_100Mhz;

  initial begin
    repeat (95000) @(posedge clk_100Mhz);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [11:0] exp_q[$];
  logic [7:0]  m_code;
  logic        m_kext, m_kbrk;
  logic        m_ext, m_brk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
  endtask

  // Byte-level model: what a host should report for one received frame.
  task automatic model_frame(input logic [7:0] b, input logic good);
    if (!good) begin
      exp_q.push_back({EV_PAR, 10'd0});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      exp_q.push_back({EV_KEY, m_ext, m_brk, b});
      m_code = b;
      m_kext = m_ext;
      m_kbrk = m_brk;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_code = 8'h00;
    m_kext = 1'b0;
    m_kbrk = 1'b0;
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2) == 0;
  endfunction

  // Monitor: every strobe is matched in order against the expected queue.
  int          n_str;
  logic [11:0] obs_ev;
  logic [11:0] want_ev;
  always @(negedge clk_100Mhz) begin
    if (rst_n) begin
      n_str = int'(key_valid) + int'(err_parity) + int'(err_timeout);
      if (n_str != 0) begin
        check("one_strobe", n_str, 1);
        if (key_valid)       obs_ev = {EV_KEY, key_ext, key_break, key_code};
        else if (err_parity) obs_ev = {EV_PAR, 10'd0};
        else                 obs_ev = {EV_TMO, 10'd0};
        if (exp_q.size() == 0) begin
          check("unexpected_event", obs_ev, 12'h000);
        end else begin
          want_ev = exp_q.pop_front();
          check("event", obs_ev, want_ev);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic v);
    PS2Data = v;
    repeat (HALF) @(negedge clk_100Mhz);
    PS2Clk = 1'b0;
    repeat (HALF) @(negedge clk_100Mhz);
    PS2Clk = 1'b1;
  endtask

  task automatic frame_done();
    check("pending", exp_q.size(), 0);
    if (exp_q.size() != 0) exp_q.delete();
    check("key_code", key_code, m_code);
    check("key_ext", key_ext, m_kext);
    check("key_break", key_break, m_kbrk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    model_frame(b, !bad_par && !bad_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(odd_par(b) ^ bad_par);
    drive_bit(!bad_stop);
    PS2Data = 1'b1;
    repeat (GAP) @(negedge clk_100Mhz);
    frame_done();
  endtask

  task automatic partial_frame(input logic [7:0] b, input int nbits);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(b[i]);
    PS2Data = 1'b1;
  endtask

  task automatic timeout_frame(input logic [7:0] b, input int nbits);
    partial_frame(b, nbits);
    exp_q.push_back({EV_TMO, 10'd0});
    m_ext = 1'b0;
    m_brk = 1'b0;
    repeat (TIMEOUT_CYCLES + 100) @(negedge clk_100Mhz);
    frame_done();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_code"}, key_code, 8'h00);
    check({tag, "_ext"}, key_ext, 1'b0);
    check({tag, "_brk"}, key_break, 1'b0);
    check({tag, "_valid"}, key_valid, 1'b0);
    check({tag, "_errp"}, err_parity, 1'b0);
    check({tag, "_errt"}, err_timeout, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  int          r_kind, r_sel, r_err;
  logic [7:0]  r_byte;

  initial begin
    rst_n   = 1'b0;
    PS2Clk  = 1'b1;
    PS2Data = 1'b1;
    model_reset();
    repeat (5) @(negedge clk_100Mhz);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk_100Mhz);

    // Plain make code, then break, then extended break, then flags cleared.
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);

    // Bad parity drops the byte and clears a pending break prefix.
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1);

    // Abandoned frame, then recovery.
    send_frame(8'hF0, 1'b0, 1'b0);
    timeout_frame(8'h29, 5);
    send_frame(8'h29, 1'b0, 1'b0);

    // Glitches on an idle bus: short one filtered, 200 ns one seen with data high.
    PS2Clk = 1'b0;
    repeat (5) @(negedge clk_100Mhz);
    PS2Clk = 1'b1;
    repeat (30) @(negedge clk_100Mhz);
    PS2Clk = 1'b0;
    repeat (20) @(negedge clk_100Mhz);
    PS2Clk = 1'b1;
    repeat (GAP) @(negedge clk_100Mhz);
    frame_done();
    send_frame(8'h33, 1'b0, 1'b0);

    // Reset mid-frame discards everything.
    send_frame(8'hE0, 1'b0, 1'b0);
    partial_frame(8'h5A, 4);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_100Mhz);
    check_reset_outputs("midrst");
    model_reset();
    rst_n = 1'b1;
    repeat (20) @(negedge clk_100Mhz);
    send_frame(8'h5A, 1'b0, 1'b0);

    // Randomized frames with prefix bias and occasional errors/timeouts.
    for (int n = 0; n < 50; n++) begin
      r_kind = $urandom_range(0, 99);
      r_sel  = $urandom_range(0, 9);
      r_err  = $urandom_range(0, 19);
      r_byte = 8'($urandom);
      if (r_sel <= 2)      r_byte = 8'hE0;
      else if (r_sel <= 4) r_byte = 8'hF0;
      if (r_kind < 5) timeout_frame(r_byte, $urandom_range(1, 7));
      else            send_frame(r_byte, r_err == 0, r_err == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
